// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a downstream 4:1 mux through channels 0..3, holding each
// select for DWELL cycles, after a one-cycle start request.
// Optional feature: define MUX_SCAN_READBACK_EN to add the z1 input and the rdata
// output, which capture the mux output on each channel's last dwell cycle.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] din,
`ifdef MUX_SCAN_READBACK_EN
  input  logic       z1,
  output logic [3:0] rdata,
`endif
  output logic [3:0] d,
  output logic [1:0] s,
  output logic       enbl,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last dwell count for a channel.
  localparam logic [7:0] DLAST = 8'(DWELL - 1);

  state_t     state_reg, state_next;
  logic [3:0] d_reg, d_next;
  logic [1:0] s_reg, s_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       enbl_reg, enbl_next;
  logic       done_reg, done_next;
  logic       accept;    // start taken in IDLE this cycle
  logic       chan_end;  // final dwell cycle of the current channel, not aborted

  // Next-state and next-output logic for the scan sequence.
  always_comb begin
    state_next = state_reg;
    d_next     = d_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    enbl_next  = enbl_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    chan_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          accept     = 1'b1;
          d_next     = din;
          s_next     = 2'd0;
          cnt_next   = 8'd0;
          enbl_next  = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          // cancel: drop enable and select, keep the captured data word
          s_next     = 2'd0;
          cnt_next   = 8'd0;
          enbl_next  = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg == DLAST) begin
          chan_end = 1'b1;
          cnt_next = 8'd0;
          if (s_reg == 2'd3) begin
            enbl_next  = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            s_next = s_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: begin
        // single-cycle completion state; select returns to channel 0
        s_next     = 2'd0;
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
      default: begin
        s_next     = 2'd0;
        cnt_next   = 8'd0;
        enbl_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      d_reg     <= 4'd0;
      s_reg     <= 2'd0;
      cnt_reg   <= 8'd0;
      enbl_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      d_reg     <= d_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      enbl_reg  <= enbl_next;
      done_reg  <= done_next;
    end
  end

  assign d    = d_reg;
  assign s    = s_reg;
  assign enbl = enbl_reg;
  assign busy = (state_reg == SCAN);
  assign done = done_reg;

`ifdef MUX_SCAN_READBACK_EN
  logic [3:0] rdata_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rdata
      // Each bit captures the mux output at the end of its own channel's dwell.
      always_ff @(posedge clk) begin
        if (rst || accept) begin
          rdata_reg[gi] <= 1'b0;
        end else if (chan_end && (s_reg == 2'(gi))) begin
          rdata_reg[gi] <= z1;
        end
      end
    end
  endgenerate

  assign rdata = rdata_reg;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: drives two instances (DWELL=4 and DWELL=1) with the same
// stimulus and compares every output each cycle against an elapsed-time model.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort;
  logic [3:0] din;

  logic [3:0] d0, d1;
  logic [1:0] s0, s1;
  logic       en0, en1, b0, b1, dn0, dn1;
  logic [3:0] rd0, rd1;

`ifdef MUX_SCAN_READBACK_EN
  // downstream 4:1 mux: selected data bit while enabled, else 0
  logic z0, zz1;
  assign z0  = en0 ? d0[s0] : 1'b0;
  assign zz1 = en1 ? d1[s1] : 1'b0;
`else
  assign rd0 = 4'd0;
  assign rd1 = 4'd0;
`endif

  mux_scan_ctrl #(.DWELL(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
`ifdef MUX_SCAN_READBACK_EN
    .z1(z0), .rdata(rd0),
`endif
    .d(d0), .s(s0), .enbl(en0), .busy(b0), .done(dn0)
  );

  mux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
`ifdef MUX_SCAN_READBACK_EN
    .z1(zz1), .rdata(rd1),
`endif
    .d(d1), .s(s1), .enbl(en1), .busy(b1), .done(dn1)
  );

  // Reference model: phase (0 idle, 1 scanning, 2 done) plus cycles elapsed in scan.
  int         m_ph[2];
  int         m_t[2];
  logic [3:0] m_d[2];
  logic [3:0] m_rd[2];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_done0  = 0;

  function automatic int dwell(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  // Advance the model by one clock edge using the currently applied inputs.
  task automatic step_model();
    for (int i = 0; i < 2; i++) begin
      int dw;
      dw = dwell(i);
      if (rst) begin
        m_ph[i] = 0; m_t[i] = 0; m_d[i] = 4'd0; m_rd[i] = 4'd0;
      end else if (m_ph[i] == 0) begin
        if (start && !abort) begin
          m_ph[i] = 1; m_t[i] = 0; m_d[i] = din; m_rd[i] = 4'd0;
        end
      end else if (m_ph[i] == 1) begin
        if (abort) begin
          m_ph[i] = 0;
        end else begin
          if ((m_t[i] % dw) == dw - 1)
            m_rd[i][m_t[i] / dw] = m_d[i][m_t[i] / dw];
          if (m_t[i] == 4 * dw - 1) m_ph[i] = 2;
          else m_t[i] = m_t[i] + 1;
        end
      end else begin
        m_ph[i] = 0;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] dd, input logic [1:0] ss,
                            input logic e, input logic b, input logic dn, input logic [3:0] rd);
    int es;
    es = (m_ph[i] == 1) ? m_t[i] / dwell(i) : (m_ph[i] == 2) ? 3 : 0;
    check($sformatf("u%0d.d", i),    8'(dd), 8'(m_d[i]));
    check($sformatf("u%0d.s", i),    8'(ss), 8'(es));
    check($sformatf("u%0d.enbl", i), 8'(e),  8'(m_ph[i] == 1));
    check($sformatf("u%0d.busy", i), 8'(b),  8'(m_ph[i] == 1));
    check($sformatf("u%0d.done", i), 8'(dn), 8'(m_ph[i] == 2));
`ifdef MUX_SCAN_READBACK_EN
    if (dn) check($sformatf("u%0d.rdata", i), 8'(rd), 8'(m_rd[i]));
`else
    if (rd !== 4'd0) check("rdata_tied", 8'(rd), 8'd0);
`endif
  endtask

  // One clock cycle: apply inputs, let the edge happen, then compare on the falling edge.
  task automatic cycle(input logic r, input logic st, input logic ab, input logic [3:0] dv);
    rst = r; start = st; abort = ab; din = dv;
    @(posedge clk);
    step_model();
    @(negedge clk);
    if (dn0) n_done0++;
    check_inst(0, d0, s0, en0, b0, dn0, rd0);
    check_inst(1, d1, s1, en1, b1, dn1, rd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; din = 4'd0;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_t[i] = 0; m_d[i] = 4'd0; m_rd[i] = 4'd0;
    end
    // reset, then a full scan with din=1010
    cycle(1'b1, 1'b1, 1'b0, 4'hA);
    cycle(1'b1, 1'b0, 1'b1, 4'hA);
    n_done0 = 0;
    cycle(1'b0, 1'b1, 1'b0, 4'b1010);
    idle(20);
    check("single_done", 8'(n_done0), 8'd1);
    // full scan with din=F
    cycle(1'b0, 1'b1, 1'b0, 4'hF);
    idle(20);
    // second start during scan is ignored
    n_done0 = 0;
    cycle(1'b0, 1'b1, 1'b0, 4'h3);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 4'hC);
    idle(20);
    check("ignored_start_done", 8'(n_done0), 8'd1);
    // abort in channel 2, then a full scan with din=5
    cycle(1'b0, 1'b1, 1'b0, 4'h6);
    idle(8);
    cycle(1'b0, 1'b0, 1'b1, 4'h0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 4'h5);
    idle(20);
    // abort on the final scan cycle of the DWELL=4 instance
    cycle(1'b0, 1'b1, 1'b0, 4'h9);
    idle(15);
    cycle(1'b0, 1'b0, 1'b1, 4'h0);
    idle(3);
    // reset during channel 1
    cycle(1'b0, 1'b1, 1'b0, 4'h7);
    idle(5);
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    idle(2);
    // start and abort together in idle
    cycle(1'b0, 1'b1, 1'b1, 4'hE);
    idle(2);
    // readback pattern din=0110
    cycle(1'b0, 1'b1, 1'b0, 4'b0110);
    idle(20);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 29) == 0),
            4'($urandom_range(0, 15)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
